// File: rtl/need_level_regulator.sv
// Nourishment level regulator: owns an internal saturating level, tick-driven
// rate prescaler and a four-state behaviour FSM (awake, asleep, eating, digest).
module need_level_regulator #(
   parameter int unsigned LEVEL_W      = 8,
   parameter int unsigned LEVEL_INIT   = 2**(LEVEL_W-1),
   parameter int unsigned SLOW_DIV     = 16,
   parameter int unsigned FAST_DIV     = 4,
   parameter int unsigned MEAL_SET     = 2**(LEVEL_W-1),
   parameter int unsigned DIGEST_TICKS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic [7:0]         action,
   output logic [LEVEL_W-1:0] level,
   output logic [1:0]         level_q,
   output logic               hungry,
   output logic               sated,
   output logic               meal_start,
   output logic [1:0]         state
);

   localparam int unsigned PRE_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam int unsigned DIG_W = $clog2(DIGEST_TICKS + 1);

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
   localparam logic [LEVEL_W-1:0] LEVEL_RST = LEVEL_W'(LEVEL_INIT);
   localparam logic [LEVEL_W-1:0] MEAL_LVL  = LEVEL_W'(MEAL_SET);
   localparam logic [PRE_W-1:0]   SLOW_LAST = PRE_W'(SLOW_DIV - 1);
   localparam logic [PRE_W-1:0]   FAST_LAST = PRE_W'(FAST_DIV - 1);
   localparam logic [DIG_W-1:0]   DIG_LOAD  = DIG_W'(DIGEST_TICKS);

   typedef enum logic [1:0] {
      ST_AWAKE  = 2'b00,
      ST_ASLEEP = 2'b01,
      ST_EATING = 2'b10,
      ST_DIGEST = 2'b11
   } state_t;

   state_t             state_r, state_nx;
   logic [LEVEL_W-1:0] lvl_r, lvl_nx;
   logic [PRE_W-1:0]   pre_r, pre_nx;
   logic [DIG_W-1:0]   dig_r, dig_nx;
   logic               meal_r, meal_nx;
   logic [PRE_W-1:0]   pre_last;
   logic               sleep, eat;
   logic               action_unused;

   assign sleep         = action[0];
   assign eat           = action[1];
   assign action_unused = ^action[7:2];

   // Register stage for FSM state and datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_AWAKE;
         lvl_r   <= LEVEL_RST;
         pre_r   <= '0;
         dig_r   <= '0;
         meal_r  <= 1'b0;
      end else begin
         state_r <= state_nx;
         lvl_r   <= lvl_nx;
         pre_r   <= pre_nx;
         dig_r   <= dig_nx;
         meal_r  <= meal_nx;
      end
   end

   assign pre_last = (state_r == ST_ASLEEP) ? SLOW_LAST : FAST_LAST;

   // Next state, then either entry actions or a tick-driven step (never both)
   always_comb begin
      state_nx = state_r;
      lvl_nx   = lvl_r;
      pre_nx   = pre_r;
      dig_nx   = dig_r;
      meal_nx  = 1'b0;

      if (sleep) begin
         state_nx = ST_ASLEEP;
      end else if (eat) begin
         state_nx = ST_EATING;
      end else begin
         case (state_r)
            ST_EATING: state_nx = ST_DIGEST;
            ST_ASLEEP: state_nx = ST_AWAKE;
            ST_DIGEST: if (dig_r == '0) state_nx = ST_AWAKE;
            default:   state_nx = state_r;
         endcase
      end

      if (state_nx != state_r) begin
         pre_nx = '0;
         if (state_nx == ST_EATING) begin
            meal_nx = 1'b1;
            if (lvl_r < MEAL_LVL) lvl_nx = MEAL_LVL;
         end
         if (state_nx == ST_DIGEST) dig_nx = DIG_LOAD;
      end else if (tick) begin
         if (state_r == ST_DIGEST) begin
            if (dig_r != '0) dig_nx = dig_r - DIG_W'(1);
         end else if (pre_r == pre_last) begin
            pre_nx = '0;
            if (state_r == ST_EATING) begin
               if (lvl_r != LEVEL_MAX) lvl_nx = lvl_r + LEVEL_W'(1);
            end else if (lvl_r != '0) begin
               lvl_nx = lvl_r - LEVEL_W'(1);
            end
         end else begin
            pre_nx = pre_r + PRE_W'(1);
         end
      end
   end

   assign level      = lvl_r;
   assign state      = state_r;
   assign meal_start = meal_r;
   assign level_q    = lvl_r[LEVEL_W-1:LEVEL_W-2];
   assign hungry     = (lvl_r[LEVEL_W-1:LEVEL_W-2] == 2'b00);
   assign sated      = &lvl_r;

endmodule
